mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width in bits.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of XLEN-bit words stored; power of two.
REQ-003 SHALL have parameter LATENCY, default 4, cycles from accepted request to response; legal range 1..15.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_b, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1, request present this cycle.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request this cycle.
REQ-008 SHALL have port mem_addr, input, XLEN, byte address of the request.
REQ-009 SHALL have port mem_write_en, input, 1, 1 = write request, 0 = read request.
REQ-010 SHALL have port mem_data_in, input, 4 x 8, write bytes; lane 0 goes to mem_addr+0 (MSB, big-endian).
REQ-011 SHALL have port mem_data_out, output, 4 x 8, read bytes; lane 0 comes from mem_addr+0.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle pulse marking request completion.
REQ-013 SHALL have port rsp_err, output, 1, qualifies rsp_valid; request was rejected.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-015 SHALL hold req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready at a clock edge.
REQ-016 SHALL, on acceptance, capture mem_addr, mem_write_en and mem_data_in, load counter with LATENCY-1, and enter BUSY.
REQ-017 SHALL, in BUSY, decrement the counter each cycle; at counter==0 perform the access and enter RESP.
REQ-018 SHALL, in RESP, assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-019 SHALL give a rising edge of rsp_valid exactly LATENCY+1 cycles after the accepting edge.
REQ-020 SHALL present the four stored bytes on mem_data_out for a read; for a write, SHALL present the written bytes.
REQ-021 SHALL hold mem_data_out until the next response; input changes outside the accept cycle SHALL be ignored.
REQ-022 SHALL form the word index as mem_addr[2 +: log2(MEM_WORDS)]; higher address bits wrap silently.
REQ-023 SHALL keep req_valid ignored while not in IDLE; no queuing; the initiator holds the request.
REQ-024 SHALL make a write visible to any read accepted after the write's rsp_valid.

Reset
REQ-025 SHALL, on rst_b low, immediately force state=IDLE, counter=0, rsp_valid=0, rsp_err=0 and mem_data_out=0; req_ready=1 after deassertion.
REQ-026 SHALL abandon an in-flight request on reset mid-operation: no write performed and no response issued.
REQ-027 SHALL leave storage contents unaffected by reset.

Configuration
REQ-028 SHALL, with MEM_MISALIGN_CHECK_EN defined, treat a request with mem_addr[1:0]!=0 as rejected: no write, mem_data_out unchanged, and rsp_err=1 with rsp_valid after the normal latency.
REQ-029 SHALL, without MEM_MISALIGN_CHECK_EN, ignore mem_addr[1:0] (word-aligned access) and tie rsp_err to 0.

Structure
REQ-030 SHALL place XLEN default, byte_t (8-bit) type, lane-array type and FSM state enum in shared package mem_pkg.
REQ-031 SHALL implement storage in sub-module mem_array: one write port, one read port, byte-lane arrays, no reset.

Verification
REQ-032 SHALL cover: write 0x11223344 @0x10, then read @0x10 -> mem_data_out = {0x11,0x22,0x33,0x44}, rsp_valid exactly 5 cycles after each accept.
REQ-033 SHALL cover: req_valid held high during BUSY with a different address -> ignored, req_ready=0, single rsp_valid.
REQ-034 SHALL cover: write 0xAABBCCDD @0x0, read @(MEM_WORDS*4) -> wraps, returns 0xAABBCCDD.
REQ-035 SHALL cover: rst_b pulsed low 2 cycles after a write accept to 0x20 -> no rsp_valid; a later read @0x20 returns prior contents.
REQ-036 SHALL cover, with MEM_MISALIGN_CHECK_EN: write @0x22 -> rsp_valid=1, rsp_err=1, word @0x20 unchanged; without the macro, the same write lands @0x20 and rsp_err=0.
REQ-037 SHALL cover: LATENCY=1 back-to-back requests -> accept, rsp 2 cycles later, next accept the cycle after RESP.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: XLEN default, byte lanes and FSM states.
package mem_pkg;
  localparam int XLEN_DEFAULT = 32;

  typedef logic [7:0] byte_t;
  // Lane 0 is the most significant byte and maps to the lowest byte address.
  typedef byte_t [0:3] lanes_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if import mem_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) ();
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_write_en;
  lanes_t          mem_data_in;
  lanes_t          mem_data_out;
  logic            rsp_valid;
  logic            rsp_err;

  modport master (
    output req_valid, mem_addr, mem_write_en, mem_data_in,
    input  req_ready, mem_data_out, rsp_valid, rsp_err
  );

  modport slave (
    input  req_valid, mem_addr, mem_write_en, mem_data_in,
    output req_ready, mem_data_out, rsp_valid, rsp_err
  );
endinterface

// File: rtl/mem_array.sv
// Word storage split into four byte-lane arrays; one write port, one registered read port, no reset.
module mem_array import mem_pkg::*; #(
  parameter  int WORDS = 1024,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  lanes_t        wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output lanes_t        rd_data
);
  byte_t lane_mem [4][WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        lane_mem[l][wr_idx] <= wr_data[l];
      end
    end
    if (rd_en) begin
      rd_data <= {lane_mem[0][rd_idx], lane_mem[1][rd_idx],
                  lane_mem[2][rd_idx], lane_mem[3][rd_idx]};
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-request memory responder (IDLE -> BUSY -> RESP).
// Optional macro MEM_MISALIGN_CHECK_EN rejects requests whose address is not word aligned.
module mem_responder import mem_pkg::*; #(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input logic            clk,
  input logic            rst_b,
  mem_responder_if.slave bus
);
  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic          we_q;
  lanes_t        wdata_q;
  lanes_t        rdata;
  lanes_t        data_out_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          accept;
  logic          access;
  logic          misaligned;
  logic          wr_en;
  logic          rd_en;
  logic [XLEN-1:0] addr_unused;

  assign addr_unused = bus.mem_addr;
  assign accept      = (state_q == IDLE) && bus.req_valid;
  assign access      = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wr_en       = access && we_q && !misaligned;
  assign rd_en       = access && !we_q && !misaligned;

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= bus.mem_addr[2 +: AW];
      we_q    <= bus.mem_write_en;
      wdata_q <= bus.mem_data_in;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic [1:0] ofs_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      ofs_q <= bus.mem_addr[1:0];
    end
  end

  assign misaligned = (ofs_q != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The response register updates on the edge leaving RESP, giving LATENCY+1 cycles from accept.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_q == RESP);
      rsp_err_q   <= (state_q == RESP) && misaligned;
      if ((state_q == RESP) && !misaligned) begin
        data_out_q <= we_q ? wdata_q : rdata;
      end
    end
  end

  mem_array #(.WORDS(MEM_WORDS)) u_mem_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .rd_en   (rd_en),
    .rd_idx  (idx_q),
    .rd_data (rdata)
  );

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.mem_data_out = data_out_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 4 / LATENCY 1) against a transaction-level model.
module tb_mem_responder;
  import mem_pkg::*;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.XLEN(32)) bus0 ();
  mem_responder_if #(.XLEN(32)) bus1 ();

  mem_responder #(.XLEN(32), .MEM_WORDS(1024), .LATENCY(4)) dut0 (
    .clk (clk), .rst_b (rst_b), .bus (bus0.slave)
  );
  mem_responder #(.XLEN(32), .MEM_WORDS(16), .LATENCY(1)) dut1 (
    .clk (clk), .rst_b (rst_b), .bus (bus1.slave)
  );

  // Model: per instance, an outstanding request completes LATENCY+1 edges after its accept edge.
  int          lat_m [2]   = '{4, 1};
  int          words_m [2] = '{1024, 16};
  bit          m_busy [2];
  int          m_rsp [2];
  bit          m_we [2];
  logic [31:0] m_a [2];
  logic [31:0] m_d [2];
  bit          p_v [2];
  bit          p_we [2];
  logic [31:0] p_a [2];
  logic [31:0] p_d [2];
  logic [31:0] e_dout [2];
  logic [31:0] mem_m [int];
  int          act_rsp1 [$];

  function automatic logic get_ready(int d);
    return (d == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction
  function automatic logic get_valid(int d);
    return (d == 0) ? bus0.rsp_valid : bus1.rsp_valid;
  endfunction
  function automatic logic get_err(int d);
    return (d == 0) ? bus0.rsp_err : bus1.rsp_err;
  endfunction
  function automatic logic [31:0] get_dout(int d);
    return (d == 0) ? bus0.mem_data_out : bus1.mem_data_out;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    bit e_valid;
    bit e_err;
    int key;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!rst_b) begin
      m_busy[d] = 1'b0;
      p_v[d]    = 1'b0;
      e_dout[d] = 32'h0;
    end else begin
      if (m_busy[d] && (cyc == m_rsp[d])) begin
        m_busy[d] = 1'b0;
        e_valid   = 1'b1;
        key = d * 65536 + int'((m_a[d] >> 2) % words_m[d]);
        if (CHK_EN && (m_a[d][1:0] != 2'b00)) begin
          e_err = 1'b1;
        end else if (m_we[d]) begin
          mem_m[key] = m_d[d];
          e_dout[d]  = m_d[d];
        end else begin
          e_dout[d] = mem_m.exists(key) ? mem_m[key] : 32'hx;
        end
      end else if (!m_busy[d] && p_v[d]) begin
        m_busy[d] = 1'b1;
        m_rsp[d]  = cyc + lat_m[d] + 1;
        m_we[d]   = p_we[d];
        m_a[d]    = p_a[d];
        m_d[d]    = p_d[d];
      end
      p_v[d]  = (d == 0) ? bus0.req_valid : bus1.req_valid;
      p_we[d] = (d == 0) ? bus0.mem_write_en : bus1.mem_write_en;
      p_a[d]  = (d == 0) ? bus0.mem_addr : bus1.mem_addr;
      p_d[d]  = (d == 0) ? bus0.mem_data_in : bus1.mem_data_in;
    end
    chk($sformatf("dut%0d req_ready", d), 32'(get_ready(d)), 32'(!m_busy[d]));
    chk($sformatf("dut%0d rsp_valid", d), 32'(get_valid(d)), 32'(e_valid));
    chk($sformatf("dut%0d rsp_err", d), 32'(get_err(d)), 32'(e_err));
    chk($sformatf("dut%0d mem_data_out", d), get_dout(d), e_dout[d]);
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        model_step(d);
      end
      if (bus1.rsp_valid) act_rsp1.push_back(cyc);
    end
  end

  task automatic set_req(input int d, input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] dat);
    if (d == 0) begin
      bus0.req_valid = v; bus0.mem_write_en = we; bus0.mem_addr = a; bus0.mem_data_in = dat;
    end else begin
      bus1.req_valid = v; bus1.mem_write_en = we; bus1.mem_addr = a; bus1.mem_data_in = dat;
    end
  endtask

  task automatic wait_accept(input int d, output int acc);
    bit r;
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      r = get_ready(d);
      @(posedge clk);
      #2;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: no accept within 40 cycles", d);
    end
  endtask

  task automatic wait_rsp(input int d, output int rc, output logic [31:0] dout, output bit err);
    rc = -1; dout = 32'hx; err = 1'bx;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (get_valid(d)) begin
        rc = cyc; dout = get_dout(d); err = get_err(d);
        break;
      end
    end
    if (rc < 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d: no rsp_valid within 40 cycles", d);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] dat,
                     output int lat, output logic [31:0] dout, output bit err);
    int acc;
    int rc;
    set_req(d, 1'b1, we, a, dat);
    wait_accept(d, acc);
    set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_rsp(d, rc, dout, err);
    lat = rc - acc;
  endtask

  initial begin
    int          lat;
    logic [31:0] dout;
    bit          err;
    int          acc;
    int          a1;
    int          a2;
    int          pulses;
    logic [31:0] prior20;

    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(bus0.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("reset mem_data_out", bus0.mem_data_out, 32'h0);
    @(posedge clk);
    #2;
    rst_b = 1'b1;

    // Write then read back at 0x10.
    txn(0, 1'b1, 32'h10, 32'h11223344, lat, dout, err);
    chk("wr10 latency", 32'(lat), 32'd5);
    chk("wr10 data_out", dout, 32'h11223344);
    chk("wr10 err", 32'(err), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, lat, dout, err);
    chk("rd10 latency", 32'(lat), 32'd5);
    chk("rd10 data_out", dout, 32'h11223344);
    chk("rd10 lane0", 32'(bus0.mem_data_out[0]), 32'h11);

    // Address wrap: MEM_WORDS*4 aliases word 0.
    txn(0, 1'b1, 32'h0, 32'hAABBCCDD, lat, dout, err);
    txn(0, 1'b0, 32'd4096, 32'h0, lat, dout, err);
    chk("wrap read", dout, 32'hAABBCCDD);

    // Misaligned write to 0x22.
    txn(0, 1'b1, 32'h20, 32'h55667788, lat, dout, err);
    txn(0, 1'b1, 32'h22, 32'hDEADBEEF, lat, dout, err);
    chk("mis latency", 32'(lat), 32'd5);
    chk("mis err", 32'(err), CHK_EN ? 32'd1 : 32'd0);
    chk("mis data_out", dout, CHK_EN ? 32'h55667788 : 32'hDEADBEEF);
    prior20 = CHK_EN ? 32'h55667788 : 32'hDEADBEEF;
    txn(0, 1'b0, 32'h20, 32'h0, lat, dout, err);
    chk("mis rd20", dout, prior20);

    // Reset two cycles after accepting a write to 0x20.
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h01020304);
    wait_accept(0, acc);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    @(posedge clk);
    #2;
    rst_b = 1'b1;
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus0.rsp_valid) pulses++;
    end
    chk("abandon no rsp", 32'(pulses), 32'd0);
    @(posedge clk);
    #2;
    txn(0, 1'b0, 32'h20, 32'h0, lat, dout, err);
    chk("abandon rd20", dout, prior20);

    // Request held through BUSY with a different address is ignored.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_accept(0, acc);
    set_req(0, 1'b1, 1'b1, 32'h40, 32'h99999999);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("held req_ready", 32'(bus0.req_ready), 32'd0);
      @(posedge clk);
      #2;
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_rsp(0, a1, dout, err);
    chk("held rsp data", dout, 32'h11223344);
    chk("held rsp cycle", 32'(a1 - acc), 32'd5);
    pulses = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus0.rsp_valid) pulses++;
    end
    chk("held single rsp", 32'(pulses), 32'd0);
    @(posedge clk);
    #2;

    // LATENCY=1 back-to-back.
    act_rsp1.delete();
    set_req(1, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
    wait_accept(1, a1);
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    wait_accept(1, a2);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #2;
    chk("b2b accept gap", 32'(a2 - a1), 32'd3);
    chk("b2b rsp count", 32'(act_rsp1.size()), 32'd2);
    if (act_rsp1.size() == 2) begin
      chk("b2b rsp1 delay", 32'(act_rsp1[0] - a1), 32'd2);
      chk("b2b rsp2 delay", 32'(act_rsp1[1] - a2), 32'd2);
    end
    chk("b2b read data", bus1.mem_data_out, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
